// File: rtl/ft245_tx_arbiter_if.sv
// Source-side byte streams plus the FT245 out-FIFO write port, bundled for the tx arbiter.
// The arbiter takes the slave view; the sources/FIFO side takes the master view.
interface ft245_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   src_valid;
    logic [NUM_REQ-1:0]   src_last;
    logic [8*NUM_REQ-1:0] src_data;
    logic [NUM_REQ-1:0]   src_ready;
    logic                 out_fifo_full;
    logic                 out_fifo_wr;
    logic [7:0]           out_fifo_data;

    modport master (
        output src_valid, src_last, src_data, out_fifo_full,
        input  src_ready, out_fifo_wr, out_fifo_data
    );

    modport slave (
        input  src_valid, src_last, src_data, out_fifo_full,
        output src_ready, out_fifo_wr, out_fifo_data
    );
endinterface

// File: rtl/ft245_tx_arbiter.sv
// Packet-granular round-robin arbiter for the FT245 out-FIFO write port, with a
// stall watchdog that releases the port when the granted source goes quiet mid-packet.
module ft245_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ft245_tx_arbiter_if.slave    bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] pkt_len
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [IDX_W-1:0]     last_owner_reg, last_owner_next;
    logic [IDLE_W-1:0]    idle_cnt_reg, idle_cnt_next;
    logic [CNT_WIDTH-1:0] pkt_len_reg, pkt_len_next;
    logic                 timeout_reg, timeout_next;

    logic [NUM_REQ-1:0]   upper_mask;
    logic [NUM_REQ-1:0]   req_upper;
    logic [NUM_REQ-1:0]   req_sel;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     idx_chain  [NUM_REQ+1];
    logic [7:0]           data_chain [NUM_REQ+1];
    logic                 in_xfer;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 wr;

    assign idx_chain[0]  = '0;
    assign data_chain[0] = 8'h00;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign upper_mask[gi]    = (IDX_W'(gi) > last_owner_reg);
            assign idx_chain[gi+1]   = idx_chain[gi] | (pick_onehot[gi] ? IDX_W'(gi) : '0);
            assign data_chain[gi+1]  = data_chain[gi] |
                                       (grant_reg[gi] ? bus.src_data[8*gi +: 8] : 8'h00);
            assign bus.src_ready[gi] = in_xfer & grant_reg[gi] & ~bus.out_fifo_full;
        end
    endgenerate

    // Requests above the last owner win; otherwise wrap to the lowest valid index.
    assign req_upper   = bus.src_valid & upper_mask;
    assign req_sel     = (|req_upper) ? req_upper : bus.src_valid;
    assign pick_onehot = req_sel & (~req_sel + NUM_REQ'(1));

    assign in_xfer   = (state_reg == ST_XFER);
    assign sel_valid = |(bus.src_valid & grant_reg);
    assign sel_last  = |(bus.src_last & grant_reg);
    assign wr        = in_xfer & sel_valid & ~bus.out_fifo_full;

    assign bus.out_fifo_wr   = wr;
    assign bus.out_fifo_data = data_chain[NUM_REQ];

    assign grant       = grant_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign timeout_err = timeout_reg;
    assign pkt_len     = pkt_len_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            idle_cnt_reg   <= '0;
            pkt_len_reg    <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            idle_cnt_reg   <= idle_cnt_next;
            pkt_len_reg    <= pkt_len_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        idle_cnt_next   = idle_cnt_reg;
        pkt_len_next    = pkt_len_reg;
        timeout_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|bus.src_valid) begin
                    grant_next    = pick_onehot;
                    owner_next    = idx_chain[NUM_REQ];
                    pkt_len_next  = '0;
                    idle_cnt_next = '0;
                    state_next    = ST_ARB;
                end
            end
            ST_ARB: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                if (wr) begin
                    idle_cnt_next = '0;
                    if (pkt_len_reg != '1) begin
                        pkt_len_next = pkt_len_reg + CNT_WIDTH'(1);
                    end
                    if (sel_last) begin
                        last_owner_next = owner_reg;
                        grant_next      = '0;
                        state_next      = ST_IDLE;
                    end
                end else if (!sel_valid) begin
                    // A last byte in the firing cycle takes the branch above, so it wins.
                    if (idle_cnt_reg == IDLE_LIMIT) begin
                        timeout_next    = 1'b1;
                        last_owner_next = owner_reg;
                        grant_next      = '0;
                        state_next      = ST_IDLE;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule
